// File: rtl/gen_pulsos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gen_pulsos_pkg
//  Description : Shared constants and state type for the radar pulse
//                generator (generador_pulsos) and its PRI counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gen_pulsos_pkg;

    // State encoding of the pulse FSM
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TX      = 2'd1;
    localparam logic [1:0] ESCUCHA = 2'd2;
    localparam logic [1:0] FIN     = 2'd3;

    // Default counter widths
    localparam int CNT_W_DEF = 32;
    localparam int NP_W_DEF  = 16;

    // Shortest PRI that still leaves one off cycle after a one-cycle pulse
    localparam int PER_MIN = 2;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_TX      = TX,
        S_ESCUCHA = ESCUCHA,
        S_FIN     = FIN
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/contador_pri.sv
`default_nettype none
// ============================================================================
//  Module      : contador_pri
//  Description : Loadable down-counter with terminal-count flag. Holds the
//                number of cycles left in the current TX or ESCUCHA phase,
//                counting the present cycle; o_tc marks the last one.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_pri #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/generador_pulsos.sv
`default_nettype none
// ============================================================================
//  Module      : generador_pulsos
//  Description : Radar pulse-timing stage. Emits the transmit window `sinc`
//                once per PRI of `periodo` clocks, `ancho` clocks wide, for
//                a burst of `n_pulsos` PRIs (0 = continuous). Reports PRI
//                ticks, pulse index, busy and burst completion.
//                Optional RX blanking output enabled by the macro
//                GEN_PULSOS_BLANKING_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module generador_pulsos
    import gen_pulsos_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NP_W  = NP_W_DEF
`ifdef GEN_PULSOS_BLANKING_EN
    ,
    parameter int GUARD = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] periodo,
    input  logic [CNT_W-1:0] ancho,
    input  logic [NP_W-1:0]  n_pulsos,
    output logic             sinc,
    output logic             pri_tick,
    output logic [NP_W-1:0]  pulse_idx,
    output logic             busy,
`ifdef GEN_PULSOS_BLANKING_EN
    output logic             rx_blank,
`endif
    output logic             done
);

    estado_t          r_state;
    estado_t          w_state_nxt;
    logic             r_en;
    logic [CNT_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_anc_sh;
    logic [NP_W-1:0]  r_np_sh;

    logic [CNT_W-1:0] w_per_eff;
    logic [CNT_W-1:0] w_anc_eff;
    logic             w_start;
    logic             w_more;
    logic [NP_W:0]    w_idx_ext;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_tc;

    logic             w_tick_nxt;
    logic             w_done_nxt;
    logic [NP_W-1:0]  w_idx_nxt;

    // Period is floored at PER_MIN; width is capped so each PRI keeps an off cycle
    assign w_per_eff = (periodo < CNT_W'(PER_MIN)) ? CNT_W'(PER_MIN) : periodo;
    assign w_anc_eff = (ancho > (w_per_eff - CNT_W'(1))) ? (w_per_eff - CNT_W'(1)) : ancho;

    // Another PRI is owed when continuous, or when idx+1 is still inside the burst
    assign w_idx_ext = {1'b0, pulse_idx} + (NP_W+1)'(1);
    assign w_more    = (r_np_sh == '0) || (w_idx_ext < {1'b0, r_np_sh});

    contador_pri #(
        .CNT_W (CNT_W)
    ) u_contador_pri (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (1'b1),
        .o_tc       (w_cnt_tc)
    );

    // Run request is sampled once so the FSM acts on en one edge later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en <= 1'b0;
        end else begin
            r_en <= en;
        end
    end

    // Next-state, phase counter reload and next output values
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_idx_nxt   = pulse_idx;

        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_start   = 1'b1;
                    w_idx_nxt = '0;
                end
            end
            S_TX: begin
                if (w_cnt_tc) begin
                    w_state_nxt = S_ESCUCHA;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = r_per_sh - r_anc_sh;
                end
            end
            S_ESCUCHA: begin
                if (w_cnt_tc) begin
                    if (r_en && w_more) begin
                        w_start   = 1'b1;
                        w_idx_nxt = pulse_idx + NP_W'(1);
                    end else if (!w_more) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_FIN: begin
                // Hold here until en is released so a finished burst never retriggers
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A PRI start skips TX entirely when the effective width is zero
        if (w_start) begin
            w_tick_nxt = 1'b1;
            w_cnt_load = 1'b1;
            if (w_anc_eff != '0) begin
                w_state_nxt = S_TX;
                w_cnt_val   = w_anc_eff;
            end else begin
                w_state_nxt = S_ESCUCHA;
                w_cnt_val   = w_per_eff;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            sinc      <= 1'b0;
            pri_tick  <= 1'b0;
            pulse_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            sinc      <= (w_state_nxt == S_TX);
            pri_tick  <= w_tick_nxt;
            pulse_idx <= w_idx_nxt;
            busy      <= (w_state_nxt == S_TX) || (w_state_nxt == S_ESCUCHA);
            done      <= w_done_nxt;
        end
    end

    // Shadow copies of the timing inputs, refreshed only at PRI start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_per_sh <= '0;
            r_anc_sh <= '0;
            r_np_sh  <= '0;
        end else if (w_start) begin
            r_per_sh <= w_per_eff;
            r_anc_sh <= w_anc_eff;
            r_np_sh  <= n_pulsos;
        end
    end

`ifdef GEN_PULSOS_BLANKING_EN
    logic [CNT_W-1:0] r_guard;
    logic [CNT_W-1:0] w_guard_nxt;
    logic             w_blank_nxt;

    // Blank through TX, then for GUARD cycles of ESCUCHA; a new PRI clears it
    always_comb begin
        w_guard_nxt = '0;
        w_blank_nxt = 1'b0;
        if (w_state_nxt == S_TX) begin
            w_blank_nxt = 1'b1;
        end else if ((r_state == S_TX) && (w_state_nxt == S_ESCUCHA)) begin
            w_guard_nxt = CNT_W'(GUARD);
            w_blank_nxt = (GUARD > 0);
        end else if ((r_state == S_ESCUCHA) && (w_state_nxt == S_ESCUCHA) && !w_start) begin
            w_guard_nxt = (r_guard != '0) ? (r_guard - CNT_W'(1)) : '0;
            w_blank_nxt = (r_guard > CNT_W'(1));
        end
    end

    // Guard countdown and registered blanking output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_guard  <= '0;
            rx_blank <= 1'b0;
        end else begin
            r_guard  <= w_guard_nxt;
            rx_blank <= w_blank_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_generador_pulsos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_generador_pulsos
//  Description : Self-checking bench for generador_pulsos: a cycle table for
//                a short burst plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_generador_pulsos;

    localparam int CNT_W = 32;
    localparam int NP_W  = 16;
`ifdef GEN_PULSOS_BLANKING_EN
    localparam int TB_GUARD = 2;
    logic rx_blank;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] periodo;
    logic [CNT_W-1:0] ancho;
    logic [NP_W-1:0]  n_pulsos;
    logic             sinc;
    logic             pri_tick;
    logic [NP_W-1:0]  pulse_idx;
    logic             busy;
    logic             done;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    generador_pulsos #(
        .CNT_W (CNT_W),
        .NP_W  (NP_W)
`ifdef GEN_PULSOS_BLANKING_EN
        ,
        .GUARD (TB_GUARD)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .periodo   (periodo),
        .ancho     (ancho),
        .n_pulsos  (n_pulsos),
        .sinc      (sinc),
        .pri_tick  (pri_tick),
        .pulse_idx (pulse_idx),
        .busy      (busy),
`ifdef GEN_PULSOS_BLANKING_EN
        .rx_blank  (rx_blank),
`endif
        .done      (done)
    );

    typedef struct {
        logic        en;
        logic [31:0] per;
        logic [31:0] anc;
        logic [15:0] np;
        logic        e_sinc;
        logic        e_tick;
        logic [15:0] e_idx;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic s, input logic t,
                            input logic [15:0] idx, input logic b, input logic d);
        chk({tag, "_sinc"}, 32'(sinc), 32'(s));
        chk({tag, "_tick"}, 32'(pri_tick), 32'(t));
        chk({tag, "_idx"},  32'(pulse_idx), 32'(idx));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    // Checks one whole PRI starting at its first cycle; act 1 drops en, act 2 sets periodo=6
    task automatic expect_pri(input string tag, input int len, input int on, input int idx,
                              input int act_at, input int act);
        for (int c = 0; c < len; c++) begin
            chk_outs($sformatf("%s_p%0d_c%0d", tag, idx, c), (c < on), (c == 0),
                     16'(idx), 1'b1, 1'b0);
`ifdef GEN_PULSOS_BLANKING_EN
            chk($sformatf("%s_p%0d_c%0d_blank", tag, idx, c), 32'(rx_blank),
                32'((on > 0) && (c < on + TB_GUARD)));
`endif
            if (c == act_at) begin
                if (act == 1) en = 1'b0;
                else if (act == 2) periodo = 32'd6;
            end
            step();
        end
    endtask

    task automatic start_burst(input int per, input int anc, input int np);
        periodo  = 32'(per);
        ancho    = 32'(anc);
        n_pulsos = 16'(np);
        en       = 1'b1;
        step();
        step();
    endtask

    initial begin
        // periodo=3, ancho=1, n_pulsos=2, then a periodo=1/ancho=5/n_pulsos=1 boundary burst
        tbl[0]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'd3, 32'd1, 16'd2, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'd1, 32'd5, 16'd1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'd1, 32'd5, 16'd1, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'd1, 32'd5, 16'd1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 32'd1, 32'd5, 16'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 32'd1, 32'd5, 16'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 32'd1, 32'd5, 16'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};

        rst      = 1'b0;
        en       = 1'b0;
        periodo  = '0;
        ancho    = '0;
        n_pulsos = '0;
        #1;
        chk_outs("reset_async", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        step();
        step();
        chk_outs("reset_held", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk_outs("idle", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

        // Cycle table
        for (int i = 0; i < NV; i++) begin
            en       = tbl[i].en;
            periodo  = tbl[i].per;
            ancho    = tbl[i].anc;
            n_pulsos = tbl[i].np;
            step();
            chk_outs($sformatf("tbl%0d", i), tbl[i].e_sinc, tbl[i].e_tick,
                     tbl[i].e_idx, tbl[i].e_busy, tbl[i].e_done);
        end

        // 10/3 burst of 4 PRIs, done after 40 clocks
        start_burst(10, 3, 4);
        for (int p = 0; p < 4; p++) expect_pri("t1", 10, 3, p, -1, 0);
        chk_outs("t1_done", 1'b0, 1'b0, 16'd3, 1'b0, 1'b1);
        step();
        chk_outs("t1_fin", 1'b0, 1'b0, 16'd3, 1'b0, 1'b0);
        en = 1'b0;
        step();
        step();

        // Zero width keeps PRI timing; oversize width clipped to 9 on / 1 off
        start_burst(10, 0, 2);
        expect_pri("t2a", 10, 0, 0, -1, 0);
        expect_pri("t2a", 10, 0, 1, -1, 0);
        chk_outs("t2a_done", 1'b0, 1'b0, 16'd1, 1'b0, 1'b1);
        en = 1'b0;
        step();
        step();
        step();
        start_burst(10, 15, 2);
        expect_pri("t2b", 10, 9, 0, -1, 0);
        expect_pri("t2b", 10, 9, 1, -1, 0);
        chk_outs("t2b_done", 1'b0, 1'b0, 16'd1, 1'b0, 1'b1);
        en = 1'b0;
        step();
        step();
        step();

        // Continuous mode, en dropped in TX of PRI 5: PRI completes, no done
        start_burst(4, 1, 0);
        for (int p = 0; p < 5; p++) expect_pri("t3", 4, 1, p, -1, 0);
        expect_pri("t3", 4, 1, 5, 0, 1);
        chk_outs("t3_idle", 1'b0, 1'b0, 16'd5, 1'b0, 1'b0);
        step();
        step();
        chk_outs("t3_hold", 1'b0, 1'b0, 16'd5, 1'b0, 1'b0);

        // periodo changed mid-PRI 1 takes effect from PRI 2
        start_burst(10, 3, 0);
        expect_pri("t4", 10, 3, 0, -1, 0);
        expect_pri("t4", 10, 3, 1, 5, 2);
        expect_pri("t4", 6, 3, 2, -1, 0);
        expect_pri("t4", 6, 3, 3, 0, 1);
        chk_outs("t4_idle", 1'b0, 1'b0, 16'd3, 1'b0, 1'b0);
        step();

        // Async reset in TX of PRI 1, then fresh burst from idx 0
        start_burst(10, 3, 0);
        expect_pri("t5", 10, 3, 0, -1, 0);
        step();
        chk_outs("t5_pre", 1'b1, 1'b0, 16'd1, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk_outs("t5_rst", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        step();
        chk_outs("t5_wait", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        step();
        expect_pri("t5", 10, 3, 0, 0, 1);
        chk_outs("t5_end", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
